// File: rtl/cod8x3_rr.sv
// Registered 8-to-3 round-robin priority encoder with a valid/ready output.
// The search starts at ptr when idle, or just past the index being accepted.
module cod8x3_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] entrada,
    output logic [W-1:0] saida,
    output logic         valido,
    input  logic         pronto,
    output logic         mais
);

    typedef enum logic {OCIOSO, OCUPADO} state_t;

    state_t         state_reg;
    logic [W-1:0]   ptr_reg;
    logic [W-1:0]   saida_reg;
    logic           valido_reg;
    logic           mais_reg;

    logic [W-1:0]   start;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W-1:0]   idx_next;
    logic           any_req;
    logic           multi_req;
    logic           accept;

    assign accept    = (state_reg == OCUPADO) && pronto;
    // While busy the only search that matters is the one at acceptance.
    assign start     = (state_reg == OCUPADO) ? saida_reg + W'(1) : ptr_reg;
    assign any_req   = |entrada;
    assign multi_req = |(entrada & (entrada - N'(1)));

    // rot[k] is the request k positions after start, wrapping modulo N.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = entrada[start + W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
            end
        end
    end

    assign idx_next = start + off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= OCIOSO;
            ptr_reg    <= '0;
            saida_reg  <= '0;
            valido_reg <= 1'b0;
            mais_reg   <= 1'b0;
        end else begin
            case (state_reg)
                OCIOSO: begin
                    if (any_req) begin
                        saida_reg  <= idx_next;
                        mais_reg   <= multi_req;
                        valido_reg <= 1'b1;
                        state_reg  <= OCUPADO;
                    end else begin
                        valido_reg <= 1'b0;
                    end
                end
                OCUPADO: begin
                    if (accept) begin
                        ptr_reg <= start;
                        if (any_req) begin
                            saida_reg  <= idx_next;
                            mais_reg   <= multi_req;
                            valido_reg <= 1'b1;
                        end else begin
                            valido_reg <= 1'b0;
                            state_reg  <= OCIOSO;
                        end
                    end
                end
                default: begin
                    state_reg  <= OCIOSO;
                    valido_reg <= 1'b0;
                end
            endcase
        end
    end

    assign saida  = saida_reg;
    assign valido = valido_reg;
    assign mais   = mais_reg;

endmodule

// File: tb/tb_cod8x3_rr.sv
// Bench for cod8x3_rr: directed scenarios plus random traffic against a
// behavioural model of the round-robin grant rules.
module tb_cod8x3_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] entrada = 8'h00;
    logic       pronto = 1'b0;
    logic [2:0] saida;
    logic       valido;
    logic       mais;

    int checks   = 0;
    int failures = 0;

    // model state
    int         ptr_m   = 0;
    int         saida_m = 0;
    logic       valido_m = 1'b0;
    logic       mais_m   = 1'b0;

    cod8x3_rr #(.N(8), .W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .entrada(entrada),
        .saida  (saida),
        .valido (valido),
        .pronto (pronto),
        .mais   (mais)
    );

    always #5 clk = ~clk;

    function automatic int search(input int st, input logic [7:0] e);
        for (int k = 0; k < 8; k++) begin
            if (e[(st + k) % 8]) return (st + k) % 8;
        end
        return 0;
    endfunction

    function automatic logic [4:0] exp_out();
        return {valido_m, mais_m, 3'(saida_m)};
    endfunction

    // Drive inputs, clock once, advance the model, then return at negedge.
    task automatic step(input logic r, input logic [7:0] e, input logic p);
        int st;
        rst = r; entrada = e; pronto = p;
        @(posedge clk);
        if (r) begin
            ptr_m = 0; saida_m = 0; valido_m = 1'b0; mais_m = 1'b0;
        end else if (!valido_m) begin
            if (e != 0) begin
                saida_m = search(ptr_m, e);
                mais_m = ($countones(e) > 1);
                valido_m = 1'b1;
            end
        end else if (p) begin
            st = (saida_m + 1) % 8;
            ptr_m = st;
            if (e != 0) begin
                saida_m = search(st, e);
                mais_m = ($countones(e) > 1);
            end else begin
                valido_m = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF, 1'b1);
            checks++;
            if ({valido, mais, saida} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got v=%b m=%b s=%0d want 0/0/0", i, valido, mais, saida);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (valido !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got v=%b want 0", i, valido);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        step(1'b0, 8'b0010_0000, 1'b1);
        checks++;
        if ({valido, mais, saida} !== {1'b1, 1'b0, 3'd5}) begin
            failures++;
            $display("FAIL single_grant got v=%b m=%b s=%0d want 1/0/5", valido, mais, saida);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (valido !== 1'b0) begin
            failures++;
            $display("FAIL single_release got v=%b want 0", valido);
        end
        $display("test_single done");
    endtask

    task automatic test_sweep();
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'hFF, 1'b1);
            checks++;
            if ({valido, mais, saida} !== {1'b1, 1'b1, 3'(i % 8)} ||
                {valido, mais, saida} !== exp_out()) begin
                failures++;
                $display("FAIL sweep i=%0d got v=%b m=%b s=%0d want 1/1/%0d", i, valido, mais, saida, i % 8);
            end
        end
        $display("test_sweep done");
    endtask

    task automatic test_wrap();
        logic [7:0] seq_e [4] = '{8'h40, 8'h03, 8'h03, 8'h00};
        logic       seq_p [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] want  [4] = '{{2'b10, 3'd6}, {2'b11, 3'd0}, {2'b11, 3'd1}, {2'b01, 3'd1}};
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, seq_e[i], seq_p[i]);
            checks++;
            if ({valido, mais, saida} !== want[i] || {valido, mais, saida} !== exp_out()) begin
                failures++;
                $display("FAIL wrap i=%0d got %b want %b", i, {valido, mais, saida}, want[i]);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_backpressure();
        step(1'b0, 8'b1000_0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({valido, mais, saida} !== {1'b1, 1'b1, 3'd2}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b m=%b s=%0d want 1/1/2", i, valido, mais, saida);
            end
            if (i < 4) step(1'b0, 8'h01, 1'b0);
        end
        step(1'b0, 8'h01, 1'b1);
        checks++;
        if ({valido, mais, saida} !== {1'b1, 1'b0, 3'd0} || {valido, mais, saida} !== exp_out()) begin
            failures++;
            $display("FAIL bp_release got v=%b m=%b s=%0d want 1/0/0", valido, mais, saida);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        step(1'b0, 8'h10, 1'b1);
        checks++;
        if ({valido, saida} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL mid_setup got v=%b s=%0d want 1/4", valido, saida);
        end
        step(1'b1, 8'h10, 1'b0);
        checks++;
        if ({valido, mais, saida} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b m=%b s=%0d want 0/0/0", valido, mais, saida);
        end
        step(1'b0, 8'b0001_0001, 1'b0);
        checks++;
        if ({valido, mais, saida} !== {1'b1, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL mid_after got v=%b m=%b s=%0d want 1/1/0", valido, mais, saida);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic       p, r;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: e = 8'h00;
                1: e = 8'(1 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            p = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 49) == 0);
            step(r, e, p);
            checks++;
            if ({valido, mais, saida} !== exp_out()) begin
                failures++;
                $display("FAIL random i=%0d e=%h p=%b r=%b got %b want %b", i, e, p, r, {valido, mais, saida}, exp_out());
            end
        end
        $display("test_random done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_sweep();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
